// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: byte width and the
// state encodings of the drain controller that feeds uart_tx.
package uart_pkg;

  localparam int unsigned BYTE_W = 8;

  // Drain controller states; the fourth encoding is unused and recovers to READY.
  typedef enum logic [1:0] {
    ST_READY = 2'b00,
    ST_ACK   = 2'b01,
    ST_BUSY  = 2'b10
  } drain_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Byte FIFO with extra-MSB pointers.
// - Full and empty are told apart by the pointer MSB.
// - A push is accepted while full only if a pop happens in the same cycle.
// - Flush clears both pointers and the sticky overflow flag.
module sync_fifo
  import uart_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [BYTE_W-1:0] i_wr_data,
  input  logic              i_pop,
  input  logic              i_flush,
  output logic [BYTE_W-1:0] o_rd_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [AW:0]       o_level,
  output logic              o_overflow
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic              r_overflow;

  logic              w_full;
  logic              w_empty;
  logic              w_rd_ok;
  logic              w_wr_ok;
  logic              w_drop;

  // Status flags and push/pop qualification; flush suppresses both directions.
  always_comb begin
    w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
              (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    w_empty = (r_wr_ptr == r_rd_ptr);
    w_rd_ok = i_pop && !w_empty && !i_flush;
    w_wr_ok = i_push && !i_flush && (!w_full || w_rd_ok);
    w_drop  = i_push && !i_flush && w_full && !w_rd_ok;
  end

  // Pointer and sticky overflow state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else if (i_flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_rd_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Storage write; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end
  end

  assign o_rd_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_level    = r_wr_ptr - r_rd_ptr;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus drain controller in front of uart_tx.
// - Queued bytes are launched one at a time with a single-cycle tx_we strobe.
// - The controller waits for uart_tx to accept the byte (empty falls).
// - It then waits for the frame to finish (empty rises) before launching again.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              flush,
  output logic              full,
  output logic [AW:0]       level,
  output logic              overflow,
  output logic              idle,
  output logic              tx_we,
  output logic [BYTE_W-1:0] tx_din,
  input  logic              tx_empty
);

  drain_state_e      r_state;
  drain_state_e      w_next_state;
  logic              w_launch;
  logic              w_idle;
  logic              r_tx_we;
  logic [BYTE_W-1:0] r_tx_din;

  logic [BYTE_W-1:0] w_rd_data;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [AW:0]       w_fifo_level;
  logic              w_fifo_overflow;

  sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (wr_en),
    .i_wr_data  (wr_data),
    .i_pop      (w_launch),
    .i_flush    (flush),
    .o_rd_data  (w_rd_data),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty),
    .o_level    (w_fifo_level),
    .o_overflow (w_fifo_overflow)
  );

  // Drain controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_READY;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Drain controller next-state: launch, wait for accept, wait for frame end.
  always_comb begin
    w_next_state = ST_READY;
    case (r_state)
      ST_READY: w_next_state = w_launch ? ST_ACK : ST_READY;
      ST_ACK:   w_next_state = tx_empty ? ST_ACK : ST_BUSY;
      ST_BUSY:  w_next_state = tx_empty ? ST_READY : ST_BUSY;
      default:  w_next_state = ST_READY;
    endcase
  end

  // Drain controller outputs: a launch pops the FIFO; a flush blocks it.
  always_comb begin
    w_launch = 1'b0;
    w_idle   = 1'b0;
    case (r_state)
      ST_READY: begin
        w_launch = !w_fifo_empty && tx_empty && !flush;
        w_idle   = w_fifo_empty && tx_empty;
      end
      default: begin
        w_launch = 1'b0;
        w_idle   = 1'b0;
      end
    endcase
  end

  // Launch strobe and held data byte towards uart_tx.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_we  <= 1'b0;
      r_tx_din <= 8'h00;
    end else begin
      r_tx_we <= w_launch;
      if (w_launch) begin
        r_tx_din <= w_rd_data;
      end
    end
  end

  assign full     = w_fifo_full;
  assign level    = w_fifo_level;
  assign overflow = w_fifo_overflow;
  assign idle     = w_idle;
  assign tx_we    = r_tx_we;
  assign tx_din   = r_tx_din;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo (DEPTH=4).
// - A small uart_tx behavioural model (CLKS_PER_BIT=4) closes the we/din/empty loop.
// - A line decoder recovers the transmitted bytes.
module tb_uart_tx_fifo;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int CPB   = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          flush;
  logic          full;
  logic [AW:0]   level;
  logic          overflow;
  logic          idle;
  logic          tx_we;
  logic [7:0]    tx_din;
  logic          tx_empty;

  int            n_checks = 0;
  int            n_errors = 0;
  int            n_launch = 0;
  logic [7:0]    rx_q[$];

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .flush    (flush),
    .full     (full),
    .level    (level),
    .overflow (overflow),
    .idle     (idle),
    .tx_we    (tx_we),
    .tx_din   (tx_din),
    .tx_empty (tx_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // uart_tx model: accepts we while empty, shifts start + 8 data (LSB first) + stop.
  logic       m_busy;
  logic [9:0] m_frame;
  logic [3:0] m_bit;
  int         m_cnt;
  logic       line;

  assign tx_empty = ~m_busy;
  assign line     = m_busy ? m_frame[m_bit] : 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_frame <= 10'h3FF;
      m_bit   <= 4'd0;
      m_cnt   <= 0;
    end else if (!m_busy) begin
      if (tx_we) begin
        m_busy  <= 1'b1;
        m_frame <= {1'b1, tx_din, 1'b0};
        m_bit   <= 4'd0;
        m_cnt   <= 0;
      end
    end else if (m_cnt == CPB - 1) begin
      m_cnt <= 0;
      if (m_bit == 4'd9) m_busy <= 1'b0;
      else               m_bit  <= m_bit + 4'd1;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  // Line decoder: sample mid-bit, collect 8 data bits, check stop bit.
  logic       line_prev;
  logic       d_act;
  int         d_cnt;
  logic [7:0] d_byte;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_prev <= 1'b1;
      d_act     <= 1'b0;
      d_cnt     <= 0;
      d_byte    <= 8'h00;
    end else begin
      line_prev <= line;
      if (!d_act) begin
        if (line_prev && !line) begin
          d_act <= 1'b1;
          d_cnt <= 1;
        end
      end else begin
        d_cnt <= d_cnt + 1;
        if ((d_cnt % CPB) == (CPB / 2) && d_cnt > CPB) begin
          if ((d_cnt / CPB) <= 8) begin
            d_byte <= {line, d_byte[7:1]};
          end else begin
            check("stop_bit", 32'(line), 32'd1);
            rx_q.push_back(d_byte);
            d_act <= 1'b0;
          end
        end
      end
    end
  end

  // Launch monitor: count strobes and require each to last one cycle.
  logic prev_we = 1'b0;
  always @(negedge clk) begin
    if (tx_we) begin
      n_launch = n_launch + 1;
      check("we_one_cycle", 32'(prev_we), 32'd0);
    end
    prev_we <= tx_we;
  end

  task automatic wait_idle(input string tag, input int max_cyc);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      seen = idle;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic check_rx(input string tag, input logic [7:0] exp);
    logic [7:0] b;
    if (rx_q.size() == 0) begin
      check(tag, 32'hDEAD, 32'(exp));
    end else begin
      b = rx_q.pop_front();
      check(tag, 32'(b), 32'(exp));
    end
  endtask

  task automatic push_one(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] burst [4];
    int         lvl2 [4];
    int         lvl3 [5];
    int         ful3 [5];
    int         ovf3 [5];
    logic       found;

    burst = '{8'h41, 8'h42, 8'h43, 8'h44};
    lvl2  = '{1, 1, 2, 3};
    lvl3  = '{1, 2, 3, 4, 4};
    ful3  = '{0, 0, 0, 1, 1};
    ovf3  = '{0, 0, 0, 0, 1};

    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    flush   = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_full",     32'(full),     32'd0);
    check("rst_level",    32'(level),    32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_tx_we",    32'(tx_we),    32'd0);
    check("rst_tx_din",   32'(tx_din),   32'h00);
    check("rst_idle",     32'(idle),     32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte: one-cycle latency, no bypass
    n_launch = 0;
    push_one(8'h55);
    check("t1_level1",   32'(level), 32'd1);
    check("t1_we_early", 32'(tx_we), 32'd0);
    @(negedge clk);
    check("t1_we",       32'(tx_we),  32'd1);
    check("t1_din",      32'(tx_din), 32'h55);
    check("t1_level0",   32'(level),  32'd0);
    @(negedge clk);
    check("t1_we_low",   32'(tx_we),  32'd0);
    wait_idle("t1_idle", 200);
    check_rx("t1_rx", 8'h55);
    check("t1_launches", 32'(n_launch), 32'd1);
    check("t1_din_held", 32'(tx_din),   32'h55);

    // Burst of four: first byte launches while the rest queue
    n_launch = 0;
    for (int i = 0; i < 4; i++) begin
      wr_en   = 1'b1;
      wr_data = burst[i];
      @(negedge clk);
      check($sformatf("t2_level%0d", i), 32'(level), 32'(lvl2[i]));
      check($sformatf("t2_full%0d", i),  32'(full),  32'd0);
    end
    wr_en = 1'b0;
    wait_idle("t2_idle", 400);
    for (int i = 0; i < 4; i++) check_rx($sformatf("t2_rx%0d", i), burst[i]);
    check("t2_launches", 32'(n_launch), 32'd4);

    // Overflow: five pushes while transmitter busy
    push_one(8'h60);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'h61 + 8'(i);
      @(negedge clk);
      check($sformatf("t3_level%0d", i), 32'(level),    32'(lvl3[i]));
      check($sformatf("t3_full%0d", i),  32'(full),     32'(ful3[i]));
      check($sformatf("t3_ovf%0d", i),   32'(overflow), 32'(ovf3[i]));
    end
    wr_en = 1'b0;
    wait_idle("t3_idle", 400);
    check_rx("t3_rx0", 8'h60);
    check_rx("t3_rx1", 8'h61);
    check_rx("t3_rx2", 8'h62);
    check_rx("t3_rx3", 8'h63);
    check_rx("t3_rx4", 8'h64);
    check("t3_rx_extra",   32'(rx_q.size()), 32'd0);
    check("t3_ovf_sticky", 32'(overflow),    32'd1);

    // Flush during first frame: that frame completes, nothing else launches
    n_launch = 0;
    push_one(8'h70);
    push_one(8'h71);
    push_one(8'h72);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("t4_level", 32'(level),    32'd0);
    check("t4_ovf",   32'(overflow), 32'd0);
    check("t4_full",  32'(full),     32'd0);
    wait_idle("t4_idle", 200);
    repeat (10) @(negedge clk);
    check_rx("t4_rx0", 8'h70);
    check("t4_rx_extra", 32'(rx_q.size()), 32'd0);
    check("t4_launches", 32'(n_launch),    32'd1);

    // Simultaneous push and pop while full
    push_one(8'h80);
    @(negedge clk);
    for (int i = 0; i < 4; i++) push_one(8'h81 + 8'(i));
    check("t5_level_full", 32'(level), 32'd4);
    check("t5_full",       32'(full),  32'd1);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      found = tx_empty;
    end
    check("t5_tx_done", 32'(found), 32'd1);
    @(negedge clk);
    push_one(8'h85);
    check("t5_we",    32'(tx_we),    32'd1);
    check("t5_din",   32'(tx_din),   32'h81);
    check("t5_level", 32'(level),    32'd4);
    check("t5_full2", 32'(full),     32'd1);
    check("t5_ovf",   32'(overflow), 32'd0);
    wait_idle("t5_idle", 600);
    for (int i = 0; i < 6; i++) check_rx($sformatf("t5_rx%0d", i), 8'h80 + 8'(i));

    // Reset in the middle of a frame's data bits
    push_one(8'h90);
    push_one(8'h91);
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_level",  32'(level),    32'd0);
    check("t6_full",   32'(full),     32'd0);
    check("t6_ovf",    32'(overflow), 32'd0);
    check("t6_tx_we",  32'(tx_we),    32'd0);
    check("t6_tx_din", 32'(tx_din),   32'h00);
    check("t6_idle",   32'(idle),     32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    rx_q.delete();
    n_launch = 0;
    repeat (60) @(negedge clk);
    check("t6_launches", 32'(n_launch),    32'd0);
    check("t6_level2",   32'(level),       32'd0);
    check("t6_rx",       32'(rx_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
